ram_burst_reader: RTL and testbench

Parametrised burst reader that streams one frame of words from external DDR memory into a pixel/SPI/VGA consumer. It issues multi-word read commands to a memory-controller user port: command FIFO plus first-word-fall-through read-data FIFO. Outstanding words are credit-limited so the read FIFO never overflows, and data is delivered over a valid/ready stream with an end-of-frame marker. It supports single-shot and continuous (frame-wrapping) modes and a clean abort. It replaces the one-word-per-command frame reader in the camera/display path.

---
 rtl/ram_burst_reader.sv | 139 +++++++++++++
 tb/tb_ram_burst_reader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// Streams one frame of words from a memory-controller user port (cmd FIFO + FWFT read FIFO)
// to a valid/ready consumer, issuing credit-limited multi-word read commands.
module ram_burst_reader #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 30,
  parameter int BYTES_PER_WORD = 4,
  parameter int BURST_LEN      = 16,
  parameter int FRAME_WORDS    = 76800,
  parameter int RDFIFO_DEPTH   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic              cmd_en,
  output logic [5:0]        cmd_bl,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_full,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_empty,
  input  logic              rd_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);
  localparam int OUT_W = $clog2(RDFIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_d;

  logic [ADDR_W-1:0] addr, eff_addr, step;
  logic [CNT_W-1:0]  remaining, delivered, eff_rem;
  logic [OUT_W-1:0]  outstanding;
  logic [6:0]        len;
  logic              accept, frame_end, wrap, fits, issue, load_last;

  assign busy      = (state != IDLE);
  assign accept    = (state == RUN) && out_valid && out_ready;
  assign frame_end = accept && out_last && !abort;
  assign wrap      = frame_end && continuous;

  // On a continuous wrap the next frame's first command is evaluated against the
  // freshly latched address/count so it can go out on the frame-end edge.
  assign eff_addr  = wrap ? base_addr : addr;
  assign eff_rem   = wrap ? CNT_W'(FRAME_WORDS) : remaining;
  assign len       = (32'(eff_rem) < 32'(BURST_LEN)) ? 7'(eff_rem) : 7'(BURST_LEN);
  assign step      = ADDR_W'(32'(len) * 32'(BYTES_PER_WORD));
  assign fits      = (32'(outstanding) + 32'(len)) <= 32'(RDFIFO_DEPTH);
  assign issue     = (state == RUN) && !abort && (eff_rem != '0) && !cmd_full && !cmd_en && fits;

  // Index of the word being loaded: if the held word leaves this same cycle it is
  // not yet counted in delivered, so add it here.
  assign load_last = (32'(delivered) + 32'(out_valid)) == 32'(FRAME_WORDS - 1);

  always_comb begin
    state_d = state;
    rd_en   = 1'b0;
    case (state)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        rd_en = !rd_empty && (!out_valid || out_ready);
        if (abort)                          state_d = DRAIN;
        else if (frame_end && !continuous)  state_d = IDLE;
      end
      DRAIN: begin
        rd_en = !rd_empty;
        if (outstanding == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      err         <= 1'b0;
      frame_done  <= 1'b0;
      cmd_en      <= 1'b0;
      cmd_bl      <= '0;
      cmd_addr    <= '0;
      addr        <= '0;
      remaining   <= '0;
      delivered   <= '0;
      outstanding <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      state       <= state_d;
      err         <= err | rd_overflow;
      frame_done  <= frame_end;
      cmd_en      <= issue;
      outstanding <= outstanding + OUT_W'(issue ? len : 7'd0) - OUT_W'(rd_en);

      if (issue) begin
        cmd_bl    <= 6'(len - 7'd1);
        cmd_addr  <= eff_addr;
        addr      <= eff_addr + step;
        remaining <= eff_rem - CNT_W'(len);
      end else if (wrap) begin
        addr      <= base_addr;
        remaining <= CNT_W'(FRAME_WORDS);
      end

      if (wrap)        delivered <= '0;
      else if (accept) delivered <= delivered + CNT_W'(1);

      if (state == IDLE && start) begin
        addr        <= base_addr;
        remaining   <= CNT_W'(FRAME_WORDS);
        delivered   <= '0;
        outstanding <= '0;
      end

      // Words popped while draining (or on the abort cycle) are dropped.
      if (state == RUN && !abort) begin
        if (rd_en) begin
          out_valid <= 1'b1;
          out_data  <= rd_data;
          out_last  <= load_last;
        end else if (accept) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized scoreboard bench for ram_burst_reader with a queue-based memory-controller model.
`timescale 1ns/1ps
module tb_ram_burst_reader;
  localparam int DW = 32, AW = 30, BPW = 4, BL = 16, FW = 40, DEPTH = 32, LAT = 5;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, continuous = 1'b0, abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, frame_done, err, cmd_en, rd_en, out_valid, out_last;
  logic [5:0]    cmd_bl;
  logic [AW-1:0] cmd_addr;
  logic          cmd_full = 1'b0, rd_empty = 1'b1, rd_overflow = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] rd_data = '0, out_data;

  always #5 clk = ~clk;

  ram_burst_reader #(.DATA_W(DW), .ADDR_W(AW), .BYTES_PER_WORD(BPW), .BURST_LEN(BL),
                     .FRAME_WORDS(FW), .RDFIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .base_addr(base_addr), .busy(busy), .frame_done(frame_done), .err(err),
    .cmd_en(cmd_en), .cmd_bl(cmd_bl), .cmd_addr(cmd_addr), .cmd_full(cmd_full),
    .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .rd_overflow(rd_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

  typedef struct { logic [DW-1:0] data; logic last; } word_t;
  typedef struct { logic [5:0] bl; logic [AW-1:0] addr; } cmd_t;
  typedef struct { int due; logic [DW-1:0] data; } pend_t;

  word_t         exp_q[$];
  cmd_t          exp_cmd[$];
  logic [DW-1:0] rdfifo[$];
  pend_t         pend[$];

  int   checks = 0, errors = 0;
  int   cyc = 0, ncmd = 0, cmd_words = 0, pops = 0, fd_count = 0, rdy_mode = 0;
  logic last_pop = 1'b0, fd_prev = 1'b0, full_prev = 1'b0, drain_phase = 1'b0;
  logic m_pop = 1'b0, m_cmd = 1'b0;
  logic [5:0]    m_bl = '0;
  logic [AW-1:0] m_addr = '0;

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a frame is FW consecutive words from b, requested in chunks of min(BL, left).
  task automatic expect_frame(input logic [AW-1:0] b);
    word_t w;
    cmd_t  c;
    int    off, n;
    for (int i = 0; i < FW; i++) begin
      w.data = word_at(AW'(b + AW'(i * BPW)));
      w.last = (i == FW - 1);
      exp_q.push_back(w);
    end
    off = 0;
    while (off < FW) begin
      n      = (FW - off < BL) ? FW - off : BL;
      c.bl   = 6'(n - 1);
      c.addr = AW'(b + AW'(off * BPW));
      exp_cmd.push_back(c);
      off += n;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [AW-1:0] b);
    base_addr = b;
    expect_frame(b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    while (busy && n < maxc) begin tick(); n++; end
    chk(name, busy, 1'b0);
    tick();
  endtask

  task automatic wait_ncmd(input string name, input int target, input int maxc);
    int n = 0;
    while (ncmd < target && n < maxc) begin tick(); n++; end
    chk(name, ncmd >= target, 1'b1);
  endtask

  // Consumer handshake driver.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) == 0);
      2:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 1) == 0);
    endcase
  end

  // Memory controller: commands return their words LAT cycles later into an FWFT FIFO.
  always @(posedge clk) begin
    pend_t p;
    #1;
    cyc++;
    if (rst) begin
      rdfifo.delete();
      pend.delete();
    end else begin
      if (m_pop && rdfifo.size() > 0) void'(rdfifo.pop_front());
      if (m_cmd)
        for (int i = 0; i <= int'(m_bl); i++) begin
          p.due  = cyc + LAT;
          p.data = word_at(AW'(m_addr + AW'(i * BPW)));
          pend.push_back(p);
        end
      while (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        rdfifo.push_back(p.data);
      end
    end
    rd_empty = (rdfifo.size() == 0);
    rd_data  = rd_empty ? '0 : rdfifo[0];
  end

  // Monitor: compares every command and every accepted word against the scoreboard.
  always @(negedge clk) begin
    cmd_t  c;
    word_t w;
    m_pop = rst ? 1'b0 : rd_en;
    m_cmd = rst ? 1'b0 : cmd_en;
    m_bl = cmd_bl;
    m_addr = cmd_addr;
    if (rst) begin
      cmd_words = 0; pops = 0; last_pop = 1'b0; full_prev = 1'b0; fd_prev = 1'b0;
    end else begin
      if (full_prev) chk("no_cmd_while_full", cmd_en, 1'b0);
      if (cmd_en) begin
        ncmd++;
        if (exp_cmd.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected: got bl=%0d addr=%0h, expected no command", cmd_bl, cmd_addr);
        end else begin
          c = exp_cmd.pop_front();
          chk("cmd_bl", cmd_bl, c.bl);
          chk("cmd_addr", cmd_addr, c.addr);
        end
        chk("credit_limit", (cmd_words - (pops - int'(last_pop)) + int'(cmd_bl) + 1) <= DEPTH, 1'b1);
        cmd_words += int'(cmd_bl) + 1;
      end
      full_prev = cmd_full;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL word_unexpected: got %0h, expected no word", out_data);
        end else begin
          w = exp_q.pop_front();
          chk("out_data", out_data, w.data);
          chk("out_last", out_last, w.last);
        end
      end
      if (drain_phase) chk("drain_out_valid", out_valid, 1'b0);
      if (frame_done) begin
        fd_count++;
        chk("frame_done_width", fd_prev, 1'b0);
      end
      fd_prev  = frame_done;
      last_pop = rd_en;
      if (rd_en) begin
        pops++;
        chk("rd_en_nonempty", rd_empty, 1'b0);
      end
    end
  end

  initial begin
    int fd0, n0;
    logic [AW-1:0] b;
    #1 rst = 1'b1;
    #1;
    chk("rst_ctrl", {busy, frame_done, err, cmd_en, rd_en, out_valid, out_last, cmd_bl}, '0);
    chk("rst_bus", {cmd_addr, out_data}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Basic frame, full throughput, start/first-command latency
    fd0 = fd_count;
    start_frame(30'h1000);
    chk("busy_after_start", busy, 1'b1);
    chk("no_cmd_yet", cmd_en, 1'b0);
    tick();
    chk("first_cmd_en", cmd_en, 1'b1);
    wait_idle("t1_idle", 400);
    chk("t1_frame_done", fd_count - fd0, 1);
    chk("t1_words_left", exp_q.size(), 0);
    chk("t1_cmds_left", exp_cmd.size(), 0);

    // Sparse consumer
    rdy_mode = 1;
    fd0 = fd_count;
    start_frame(30'h1000);
    wait_idle("t2_idle", 1000);
    chk("t2_frame_done", fd_count - fd0, 1);
    chk("t2_words_left", exp_q.size(), 0);

    // Command FIFO stall mid-frame
    rdy_mode = 0;
    n0 = ncmd;
    start_frame(30'h2000);
    wait_ncmd("t3_first_cmd", n0 + 1, 50);
    cmd_full = 1'b1;
    repeat (20) tick();
    cmd_full = 1'b0;
    wait_idle("t3_idle", 400);
    chk("t3_cmds", ncmd - n0, 3);
    chk("t3_words_left", exp_q.size(), 0);

    // Continuous mode with base change during frame 1
    fd0 = fd_count;
    continuous = 1'b1;
    start_frame(30'h1000);
    repeat (10) tick();
    base_addr = 30'h8000;
    expect_frame(30'h8000);
    n0 = 0;
    while (fd_count == fd0 && n0 < 400) begin tick(); n0++; end
    chk("t4_first_wrap", fd_count - fd0, 1);
    continuous = 1'b0;
    wait_idle("t4_idle", 400);
    chk("t4_frame_done", fd_count - fd0, 2);
    chk("t4_words_left", exp_q.size(), 0);
    chk("t4_cmds_left", exp_cmd.size(), 0);

    // Abort with a stalled consumer: everything commanded must still be popped
    rdy_mode = 2;
    n0 = ncmd;
    start_frame(30'h3000);
    wait_ncmd("t5_two_cmds", n0 + 2, 50);
    abort = 1'b1;
    exp_q.delete();
    exp_cmd.delete();
    tick();
    abort = 1'b0;
    drain_phase = 1'b1;
    wait_idle("t5_idle", 400);
    drain_phase = 1'b0;
    chk("t5_cmds", ncmd - n0, 2);
    chk("t5_all_popped", pops, cmd_words);
    chk("t5_model_empty", rdfifo.size() + pend.size(), 0);

    // Random frames (incl. address wrap at the top of memory) with random stalls
    rdy_mode = 3;
    for (int r = 0; r < 4; r++) begin
      b = (r == 1) ? 30'h3FFF_FF80 : (AW'($urandom) & ~AW'(3));
      fd0 = fd_count;
      start_frame(b);
      n0 = 0;
      while (busy && n0 < 3000) begin
        cmd_full = ($urandom_range(0, 3) == 0);
        tick();
        n0++;
      end
      cmd_full = 1'b0;
      chk("rand_idle", busy, 1'b0);
      tick();
      chk("rand_frame_done", fd_count - fd0, 1);
      chk("rand_words_left", exp_q.size(), 0);
    end

    // Asynchronous reset mid-burst
    rdy_mode = 0;
    n0 = ncmd;
    start_frame(30'h4000);
    wait_ncmd("t7_cmds", n0 + 2, 50);
    repeat (3) tick();
    #3 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", {busy, frame_done, err, cmd_en, rd_en, out_valid, out_last, cmd_bl}, '0);
    chk("async_rst_bus", {cmd_addr, out_data}, '0);
    exp_q.delete();
    exp_cmd.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Sticky error flag
    chk("err_clear", err, 1'b0);
    rd_overflow = 1'b1;
    tick();
    rd_overflow = 1'b0;
    chk("err_set", err, 1'b1);
    repeat (5) tick();
    chk("err_sticky", err, 1'b1);
    rst = 1'b1;
    #1;
    chk("err_rst", err, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
    $fatal(1);
  end
endmodule
